// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared FSM states, wait-counter width and load/store encoding
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WCW = 4;

    localparam logic WE_LOAD  = 1'b0;
    localparam logic WE_STORE = 1'b1;

    function automatic logic is_store(input logic we);
        return we == WE_STORE;
    endfunction

endpackage

// File: rtl/rv_dmem_array.sv
// rv_dmem_array: DEPTH x DW single-port synchronous array with read-before-write
//   clk   - rising-edge clock
//   en_i  - access enable; rdata_o only updates on enabled edges
//   we_i  - write enable (store)
//   addr_i, wdata_i - word index and store data
//   rdata_o - registered read data, value held before the write on the same edge
module rv_dmem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: load/store responder with configurable wait states
//   clk, RN            - clock and asynchronous active-low reset
//   req_valid/ready    - request handshake; req_we/addr/wdata describe the access
//   rsp_valid/ready    - response handshake
//   rsp_rdata          - load data (0 for stores and out-of-range accesses)
//   rsp_err, rsp_we    - out-of-range flag and echo of the request's we bit
module rv_dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int DW       = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_we
);

    localparam int AW = $clog2(DEPTH);

    state_e         state_q, state_d;
    logic [WCW-1:0] cnt_q, cnt_d;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [DW-1:0]  wdata_q;
    logic           err_q, rwe_q, load_q;

    logic           accept, acc_now, in_range;
    logic           a_we;
    logic [31:0]    a_addr;
    logic [DW-1:0]  a_wdata, arr_rdata;

    assign req_ready = RN && state_q == IDLE;
    assign accept    = req_valid && req_ready;

    // With no wait states the access happens on the accept edge itself, so the
    // live request feeds the array; otherwise the captured copy does.
    assign a_we    = state_q == IDLE ? req_we    : we_q;
    assign a_addr  = state_q == IDLE ? req_addr  : addr_q;
    assign a_wdata = state_q == IDLE ? req_wdata : wdata_q;

    assign acc_now  = (state_q == IDLE && accept && WAIT_CYC == 0) ||
                      (state_q == WAIT && cnt_q == WCW'(1));
    // Full 32-bit compare before truncation so aliases of valid words are rejected.
    assign in_range = a_addr < 32'(DEPTH);

    rv_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_array (
        .clk     (clk),
        .en_i    (acc_now && in_range),
        .we_i    (is_store(a_we)),
        .addr_i  (a_addr[AW-1:0]),
        .wdata_i (a_wdata),
        .rdata_o (arr_rdata)
    );

    assign rsp_valid = state_q == RESP;
    // The array output only moves on access edges, so gating it keeps rdata stable in RESP.
    assign rsp_rdata = load_q ? arr_rdata : '0;
    assign rsp_err   = err_q;
    assign rsp_we    = rwe_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT_CYC == 0 ? RESP : WAIT;
                    cnt_d   = WCW'(WAIT_CYC);
                end
            end
            WAIT: begin
                cnt_d   = cnt_q - WCW'(1);
                state_d = cnt_q == WCW'(1) ? RESP : WAIT;
            end
            RESP: begin
                state_d = rsp_ready ? IDLE : RESP;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rwe_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (acc_now) begin
                err_q  <= !in_range;
                rwe_q  <= a_we;
                load_q <= in_range && !is_store(a_we);
            end
        end
    end

endmodule
